rf_wb_arbiter: RTL

//  Sole owner of the register-file write port; drives it from two sources.

---
 rtl/rf_wb_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the long-latency
// unit is served by handshake with a starvation guard and a pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              lu_issue,
    input  logic [ADDR_W-1:0] lu_issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd_chk,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  starve_cnt, cnt_next;
    logic [NREG-1:0]   pending, pending_next;
    logic              wb_act;
    logic              lu_denied;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
            pending    <= '0;
            wb_stall   <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= cnt_next;
            pending    <= pending_next;
            wb_stall   <= (state_next == FORCE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        lu_denied  = lu_valid & ~lu_ready;
        case (state)
            NORMAL: begin
                if (lu_denied) begin
                    if (starve_cnt == CNT_LAST) begin
                        state_next = FORCE;
                    end else begin
                        cnt_next = starve_cnt + 1'b1;
                    end
                end
            end
            FORCE: begin
                state_next = NORMAL;
            end
            default: begin
                state_next = NORMAL;
            end
        endcase

        // Set is applied after clear so a same-cycle issue/completion of one rd stays pending.
        pending_next = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            pending_next[i] = pending[i] & ~(lu_ready & (lu_rd == ADDR_W'(i)));
            if (lu_issue && (lu_issue_rd == ADDR_W'(i))) begin
                pending_next[i] = 1'b1;
            end
        end
    end

    always_comb begin
        wb_act   = wb_valid & ~wb_stall & (state == NORMAL);
        lu_ready = rst_n & lu_valid & ~wb_act;
        if (wb_act) begin
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else begin
            rf_waddr = lu_rd;
            rf_wdata = lu_data;
        end
        rf_we    = rst_n & (wb_act | lu_valid) & (rf_waddr != '0);
        rs1_busy = pending[rs1];
        rs2_busy = pending[rs2];
        rd_busy  = pending[rd_chk];
    end

endmodule
